sram_address_manager: RTL and testbench

SRAM_ADDRESS_MANAGER -- requirements
Module: sram_address_manager

---
 rtl/sram_addr_pkg.sv | 20 ++
 rtl/rise_detect.sv | 22 ++
 rtl/sram_address_manager.sv | 142 ++++++++++++++
 tb/tb_sram_address_manager.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_addr_pkg.sv
// rtl/sram_addr_pkg.sv - shared constants and pointer type for the SRAM circular-buffer address manager
package sram_addr_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 18;
  // Pointer address field is sized for the widest supported build; unused upper bits stay zero.
  localparam int unsigned MAX_ADDR_W = 30;

  localparam int unsigned CAP_SINGLE_DEFAULT = 32'd1 << DEFAULT_ADDR_W;
  localparam int unsigned CAP_DUAL_DEFAULT   = 32'd1 << (DEFAULT_ADDR_W + 1);

  typedef struct packed {
    logic                  chip;
    logic [MAX_ADDR_W-1:0] address;
  } sram_ptr_t;

  function automatic int unsigned capacity_words(input int unsigned addr_w, input bit dual_chip);
    return dual_chip ? (32'd1 << (addr_w + 1)) : (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge detector: registered previous level, one-cycle pulse out
module rise_detect (
  input  logic CLK_48MHZ,
  input  logic RESET,
  input  logic level,
  output logic rise
);

  logic level_prev;

  // Clearing history on reset makes a level already high at release count as one edge.
  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      level_prev <= 1'b0;
    end else begin
      level_prev <= level;
    end
  end

  assign rise = level & ~level_prev;

endmodule

// File: rtl/sram_address_manager.sv
// rtl/sram_address_manager.sv - SRAM circular-buffer read/write pointer and occupancy manager
// Define SRAM_DUAL_CHIP_EN for the two-chip build (pointer = {chip, address}).
module sram_address_manager
  import sram_addr_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned AF_MARGIN = 16
) (
  input  logic              CLK_48MHZ,
  input  logic              RESET,
  input  logic              NEXT_WRITE,
  input  logic              NEXT_READ,
  input  logic              CLEAR,
  output logic [ADDR_W-1:0] WRITE_ADDRESS,
  output logic              WRITE_CHIP_SELECT,
  output logic [ADDR_W-1:0] READ_ADDRESS,
  output logic              READ_CHIP_SELECT,
  output logic [ADDR_W+1:0] WORD_COUNT,
  output logic              EMPTY,
  output logic              FULL,
  output logic              ALMOST_FULL,
  output logic              OVERFLOW
);

`ifdef SRAM_DUAL_CHIP_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  localparam int unsigned CW        = ADDR_W + 2;
  localparam int unsigned CAP_WORDS = capacity_words(ADDR_W, DUAL);

  localparam logic [CW-1:0]         CAP       = CW'(CAP_WORDS);
  localparam logic [CW-1:0]         AF_LEVEL  = CW'(CAP_WORDS - AF_MARGIN);
  localparam logic [CW-1:0]         COUNT_ONE = CW'(1);
  localparam logic [MAX_ADDR_W-1:0] ADDR_MAX  = MAX_ADDR_W'((32'd1 << ADDR_W) - 32'd1);
  localparam logic [MAX_ADDR_W-1:0] ADDR_ONE  = MAX_ADDR_W'(1);

  sram_ptr_t     wr_ptr, wr_ptr_n;
  sram_ptr_t     rd_ptr, rd_ptr_n;
  logic [CW-1:0] count_q, count_n;
  logic          empty_q, full_q, af_q, ovf_q;
  logic          empty_n, full_n, af_n, ovf_n;
  logic          write_rise, read_rise;

  rise_detect u_write_rise (
    .CLK_48MHZ (CLK_48MHZ),
    .RESET     (RESET),
    .level     (NEXT_WRITE),
    .rise      (write_rise)
  );

  rise_detect u_read_rise (
    .CLK_48MHZ (CLK_48MHZ),
    .RESET     (RESET),
    .level     (NEXT_READ),
    .rise      (read_rise)
  );

  // Single-chip builds never toggle the chip bit, so it stays at its reset value of 0.
  function automatic sram_ptr_t ptr_inc(input sram_ptr_t p);
    sram_ptr_t n;
    n = p;
    if (p.address == ADDR_MAX) begin
      n.address = '0;
      n.chip    = DUAL ? ~p.chip : 1'b0;
    end else begin
      n.address = p.address + ADDR_ONE;
    end
    return n;
  endfunction

  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count_q;
    ovf_n    = ovf_q;

    if (CLEAR) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
      ovf_n    = 1'b0;
    end else if (write_rise && full_q) begin
      // Overwrite the oldest word: the read pointer is dragged along.
      wr_ptr_n = ptr_inc(wr_ptr);
      rd_ptr_n = ptr_inc(rd_ptr);
      ovf_n    = 1'b1;
    end else if (write_rise && read_rise && !empty_q) begin
      wr_ptr_n = ptr_inc(wr_ptr);
      rd_ptr_n = ptr_inc(rd_ptr);
    end else if (write_rise) begin
      wr_ptr_n = ptr_inc(wr_ptr);
      count_n  = count_q + COUNT_ONE;
    end else if (read_rise && !empty_q) begin
      rd_ptr_n = ptr_inc(rd_ptr);
      count_n  = count_q - COUNT_ONE;
    end

    empty_n = (count_n == '0);
    full_n  = (count_n == CAP);
    af_n    = (count_n >= AF_LEVEL);
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      count_q <= count_n;
      empty_q <= empty_n;
      full_q  <= full_n;
      af_q    <= af_n;
      ovf_q   <= ovf_n;
    end
  end

  assign WRITE_ADDRESS = wr_ptr.address[ADDR_W-1:0];
  assign READ_ADDRESS  = rd_ptr.address[ADDR_W-1:0];
  assign WORD_COUNT    = count_q;
  assign EMPTY         = empty_q;
  assign FULL          = full_q;
  assign ALMOST_FULL   = af_q;
  assign OVERFLOW      = ovf_q;

`ifdef SRAM_DUAL_CHIP_EN
  assign WRITE_CHIP_SELECT = wr_ptr.chip;
  assign READ_CHIP_SELECT  = rd_ptr.chip;
`else
  assign WRITE_CHIP_SELECT = 1'b0;
  assign READ_CHIP_SELECT  = 1'b0;
`endif

endmodule

// File: tb/tb_sram_address_manager.sv
// tb/tb_sram_address_manager.sv - directed self-checking bench for sram_address_manager
module tb_sram_address_manager;

  localparam int AW = 4;
  localparam int CW = AW + 2;
`ifdef SRAM_DUAL_CHIP_EN
  localparam int   CAP       = 32;
  localparam logic WRAP_CHIP = 1'b1;
`else
  localparam int   CAP       = 16;
  localparam logic WRAP_CHIP = 1'b0;
`endif
  localparam logic [CW-1:0] CAP_W     = CW'(CAP);
  localparam logic          WRAP_FULL = (CAP == 16);

  logic          CLK_48MHZ = 1'b0;
  logic          RESET = 1'b1;
  logic          NEXT_WRITE = 1'b0;
  logic          NEXT_READ = 1'b0;
  logic          CLEAR = 1'b0;
  logic [AW-1:0] WRITE_ADDRESS, READ_ADDRESS;
  logic          WRITE_CHIP_SELECT, READ_CHIP_SELECT;
  logic [CW-1:0] WORD_COUNT;
  logic          EMPTY, FULL, ALMOST_FULL, OVERFLOW;

  int vectors = 0;
  int miscompares = 0;

  sram_address_manager #(.ADDR_W(AW), .AF_MARGIN(3)) dut (
    .CLK_48MHZ         (CLK_48MHZ),
    .RESET             (RESET),
    .NEXT_WRITE        (NEXT_WRITE),
    .NEXT_READ         (NEXT_READ),
    .CLEAR             (CLEAR),
    .WRITE_ADDRESS     (WRITE_ADDRESS),
    .WRITE_CHIP_SELECT (WRITE_CHIP_SELECT),
    .READ_ADDRESS      (READ_ADDRESS),
    .READ_CHIP_SELECT  (READ_CHIP_SELECT),
    .WORD_COUNT        (WORD_COUNT),
    .EMPTY             (EMPTY),
    .FULL              (FULL),
    .ALMOST_FULL       (ALMOST_FULL),
    .OVERFLOW          (OVERFLOW)
  );

  always #10 CLK_48MHZ = ~CLK_48MHZ;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge CLK_48MHZ);
    RESET = 1'b1; NEXT_WRITE = 1'b0; NEXT_READ = 1'b0; CLEAR = 1'b0;
    @(negedge CLK_48MHZ);
    @(negedge CLK_48MHZ);
    RESET = 1'b0;
  endtask

  task automatic pulse(input logic w, input logic r);
    @(negedge CLK_48MHZ);
    NEXT_WRITE = w; NEXT_READ = r;
    @(negedge CLK_48MHZ);
    NEXT_WRITE = 1'b0; NEXT_READ = 1'b0;
  endtask

  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) pulse(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({WRITE_ADDRESS, WRITE_CHIP_SELECT, READ_ADDRESS, READ_CHIP_SELECT} !== 10'h0) begin
      miscompares++;
      $display("FAIL reset.pointers got %0h want 0", {WRITE_ADDRESS, WRITE_CHIP_SELECT, READ_ADDRESS, READ_CHIP_SELECT});
    end
    vectors++;
    if (WORD_COUNT !== 6'd0) begin
      miscompares++; $display("FAIL reset.count got %0d want 0", WORD_COUNT);
    end
    vectors++;
    if ({EMPTY, FULL, ALMOST_FULL, OVERFLOW} !== 4'b1000) begin
      miscompares++; $display("FAIL reset.flags got %b want 1000", {EMPTY, FULL, ALMOST_FULL, OVERFLOW});
    end
  endtask

  task automatic test_three_writes();
    do_reset();
    write_n(3);
    vectors++;
    if ({WRITE_ADDRESS, READ_ADDRESS} !== {4'h3, 4'h0}) begin
      miscompares++; $display("FAIL three_writes.addr got wa=%0h ra=%0h want wa=3 ra=0", WRITE_ADDRESS, READ_ADDRESS);
    end
    vectors++;
    if ({WORD_COUNT, EMPTY} !== {6'd3, 1'b0}) begin
      miscompares++; $display("FAIL three_writes.count got %0d empty=%b want 3 empty=0", WORD_COUNT, EMPTY);
    end
  endtask

  task automatic test_held_high();
    do_reset();
    @(negedge CLK_48MHZ);
    NEXT_WRITE = 1'b1;
    @(negedge CLK_48MHZ);
    vectors++;
    if (WRITE_ADDRESS !== 4'h1) begin
      miscompares++; $display("FAIL held_high.latency got %0h want 1", WRITE_ADDRESS);
    end
    repeat (9) @(negedge CLK_48MHZ);
    NEXT_WRITE = 1'b0;
    @(negedge CLK_48MHZ);
    vectors++;
    if ({WRITE_ADDRESS, WORD_COUNT} !== {4'h1, 6'd1}) begin
      miscompares++; $display("FAIL held_high.once got wa=%0h cnt=%0d want wa=1 cnt=1", WRITE_ADDRESS, WORD_COUNT);
    end
  endtask

  task automatic test_release_high();
    @(negedge CLK_48MHZ);
    RESET = 1'b1; NEXT_WRITE = 1'b1;
    @(negedge CLK_48MHZ);
    @(negedge CLK_48MHZ);
    RESET = 1'b0;
    vectors++;
    if (WRITE_ADDRESS !== 4'h0) begin
      miscompares++; $display("FAIL release_high.in_reset got %0h want 0", WRITE_ADDRESS);
    end
    @(negedge CLK_48MHZ);
    @(negedge CLK_48MHZ);
    NEXT_WRITE = 1'b0;
    vectors++;
    if ({WRITE_ADDRESS, WORD_COUNT} !== {4'h1, 6'd1}) begin
      miscompares++; $display("FAIL release_high.one_edge got wa=%0h cnt=%0d want wa=1 cnt=1", WRITE_ADDRESS, WORD_COUNT);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    write_n(15);
    vectors++;
    if ({WRITE_CHIP_SELECT, WRITE_ADDRESS} !== {1'b0, 4'hF}) begin
      miscompares++; $display("FAIL wrap.at_max got cs=%b wa=%0h want cs=0 wa=f", WRITE_CHIP_SELECT, WRITE_ADDRESS);
    end
    write_n(1);
    vectors++;
    if ({WRITE_CHIP_SELECT, WRITE_ADDRESS} !== {WRAP_CHIP, 4'h0}) begin
      miscompares++; $display("FAIL wrap.rollover got cs=%b wa=%0h want cs=%b wa=0", WRITE_CHIP_SELECT, WRITE_ADDRESS, WRAP_CHIP);
    end
    vectors++;
    if ({WORD_COUNT, FULL} !== {6'd16, WRAP_FULL}) begin
      miscompares++; $display("FAIL wrap.count got %0d full=%b want 16 full=%b", WORD_COUNT, FULL, WRAP_FULL);
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    write_n(CAP - 4);
    vectors++;
    if ({ALMOST_FULL, FULL} !== 2'b00) begin
      miscompares++; $display("FAIL full.below_af got af=%b full=%b want 00", ALMOST_FULL, FULL);
    end
    write_n(1);
    vectors++;
    if ({ALMOST_FULL, FULL} !== 2'b10) begin
      miscompares++; $display("FAIL full.at_af got af=%b full=%b want 10", ALMOST_FULL, FULL);
    end
    write_n(3);
    vectors++;
    if ({WORD_COUNT, FULL, OVERFLOW} !== {CAP_W, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL full.at_cap got cnt=%0d full=%b ovf=%b want %0d 1 0", WORD_COUNT, FULL, OVERFLOW, CAP);
    end
    vectors++;
    if ({WRITE_CHIP_SELECT, WRITE_ADDRESS, READ_CHIP_SELECT, READ_ADDRESS} !== 10'h0) begin
      miscompares++; $display("FAIL full.ptrs_equal got wa=%0h ra=%0h want both 0", WRITE_ADDRESS, READ_ADDRESS);
    end
    write_n(1);
    vectors++;
    if ({WRITE_ADDRESS, READ_ADDRESS} !== {4'h1, 4'h1}) begin
      miscompares++; $display("FAIL overflow.ptrs got wa=%0h ra=%0h want 1 1", WRITE_ADDRESS, READ_ADDRESS);
    end
    vectors++;
    if ({WORD_COUNT, FULL, OVERFLOW} !== {CAP_W, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL overflow.state got cnt=%0d full=%b ovf=%b want %0d 1 1", WORD_COUNT, FULL, OVERFLOW, CAP);
    end
    pulse(1'b0, 1'b1);
    vectors++;
    if ({READ_ADDRESS, WORD_COUNT, FULL, OVERFLOW} !== {4'h2, CAP_W - 6'd1, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL overflow.sticky got ra=%0h cnt=%0d full=%b ovf=%b", READ_ADDRESS, WORD_COUNT, FULL, OVERFLOW);
    end
  endtask

  task automatic test_clear();
    @(negedge CLK_48MHZ);
    CLEAR = 1'b1; NEXT_WRITE = 1'b1;
    @(negedge CLK_48MHZ);
    CLEAR = 1'b0;
    vectors++;
    if ({WRITE_ADDRESS, READ_ADDRESS, WORD_COUNT} !== 14'h0) begin
      miscompares++; $display("FAIL clear.zero got wa=%0h ra=%0h cnt=%0d want 0", WRITE_ADDRESS, READ_ADDRESS, WORD_COUNT);
    end
    vectors++;
    if ({EMPTY, OVERFLOW} !== 2'b10) begin
      miscompares++; $display("FAIL clear.flags got empty=%b ovf=%b want 1 0", EMPTY, OVERFLOW);
    end
    @(negedge CLK_48MHZ);
    NEXT_WRITE = 1'b0;
    vectors++;
    if (WRITE_ADDRESS !== 4'h0) begin
      miscompares++; $display("FAIL clear.history got wa=%0h want 0", WRITE_ADDRESS);
    end
  endtask

  task automatic test_empty_read();
    do_reset();
    pulse(1'b0, 1'b1);
    vectors++;
    if ({READ_ADDRESS, WORD_COUNT, EMPTY} !== {4'h0, 6'd0, 1'b1}) begin
      miscompares++; $display("FAIL empty_read got ra=%0h cnt=%0d empty=%b want 0 0 1", READ_ADDRESS, WORD_COUNT, EMPTY);
    end
    pulse(1'b1, 1'b1);
    vectors++;
    if ({WRITE_ADDRESS, READ_ADDRESS, WORD_COUNT} !== {4'h1, 4'h0, 6'd1}) begin
      miscompares++; $display("FAIL simul_empty got wa=%0h ra=%0h cnt=%0d want 1 0 1", WRITE_ADDRESS, READ_ADDRESS, WORD_COUNT);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    write_n(5);
    pulse(1'b1, 1'b1);
    vectors++;
    if ({WRITE_ADDRESS, READ_ADDRESS, WORD_COUNT} !== {4'h6, 4'h1, 6'd5}) begin
      miscompares++; $display("FAIL back_to_back got wa=%0h ra=%0h cnt=%0d want 6 1 5", WRITE_ADDRESS, READ_ADDRESS, WORD_COUNT);
    end
  endtask

  task automatic test_reset_override();
    do_reset();
    write_n(4);
    @(negedge CLK_48MHZ);
    RESET = 1'b1; CLEAR = 1'b1; NEXT_WRITE = 1'b1;
    @(negedge CLK_48MHZ);
    vectors++;
    if ({WRITE_ADDRESS, WORD_COUNT, EMPTY, OVERFLOW} !== {4'h0, 6'd0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL reset_override got wa=%0h cnt=%0d empty=%b", WRITE_ADDRESS, WORD_COUNT, EMPTY);
    end
    NEXT_WRITE = 1'b0; CLEAR = 1'b0;
    @(negedge CLK_48MHZ);
    RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_three_writes();
    test_held_high();
    test_release_high();
    test_wrap();
    test_full_overflow();
    test_clear();
    test_empty_read();
    test_back_to_back();
    test_reset_override();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
